// File: rtl/id_ex_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_reg_pkg
// Purpose : Shared constants for the ID/EX pipeline register and its
//           multiply interlock. Holds the funct codes the ALU understands,
//           the default widths, and the bubble encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package id_ex_reg_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int FUNCT_W_DEF     = 6;
  localparam int REG_W_DEF       = 5;
  localparam int MULT_CYCLES_DEF = 32;

  typedef enum logic [5:0] {
    FUNCT_SLL   = 6'd0,
    FUNCT_MFHI  = 6'd16,
    FUNCT_MFLO  = 6'd18,
    FUNCT_MULTU = 6'd25,
    FUNCT_ADD   = 6'd32,
    FUNCT_SUB   = 6'd34,
    FUNCT_AND   = 6'd36,
    FUNCT_OR    = 6'd37,
    FUNCT_SLT   = 6'd42
  } funct_e;

  // A bubble is an SLL with regwrite cleared: the ALU computes something,
  // but nothing is ever written back, so it is architecturally invisible.
  localparam funct_e BUBBLE_FUNCT = FUNCT_SLL;

endpackage
`default_nettype wire

// File: rtl/id_ex_reg_mult_interlock.sv
`default_nettype none
// ============================================================================
// Module  : mult_interlock
// Purpose : Tracks the multi-cycle MULTU running in the execute stage and
//           flags decode-stage instructions that would touch Hi/Lo early.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           load_multu      - a valid MULTU is being loaded into ID/EX
//           in_valid        - decode presents an instruction
//           in_funct        - funct code of the presented instruction
//           mult_busy       - product not yet available in Hi/Lo
//           hazard          - presented instruction must wait for Hi/Lo
// Revision: 1.0 - initial release
// ============================================================================
module mult_interlock
  import id_ex_reg_pkg::*;
#(
  parameter int FUNCT_W     = FUNCT_W_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_multu,
  input  logic               in_valid,
  input  logic [FUNCT_W-1:0] in_funct,
  output logic               mult_busy,
  output logic               hazard
);

  localparam int CNT_W = $clog2(MULT_CYCLES + 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             hilo_user;

  // The multiplier runs on its own once started, so the count keeps moving
  // regardless of pipeline stalls or flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (load_multu) begin
      busy_cnt <= CNT_W'(MULT_CYCLES);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - CNT_W'(1);
    end
  end

  assign mult_busy = (busy_cnt != '0);

  // MFHI/MFLO would read a stale Hi/Lo; a second MULTU would clobber the
  // result still being produced.
  assign hilo_user = (in_funct == FUNCT_W'(FUNCT_MFHI))
                   | (in_funct == FUNCT_W'(FUNCT_MFLO))
                   | (in_funct == FUNCT_W'(FUNCT_MULTU));

  assign hazard = in_valid & mult_busy & hilo_user;

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_reg
// Purpose : ID/EX pipeline register feeding the execute-stage ALU, with the
//           Hi/Lo multiply interlock, downstream hold and flush support.
// Ports   : clk, rst                      - clock, async active-high reset
//           in_valid/in_funct/in_dataA/in_dataB/in_rd/in_regwrite
//                                         - instruction from decode
//           ex_stall                      - hold register contents
//           flush                         - replace presented instr with bubble
//           out_valid/out_funct/out_dataA/out_dataB/out_rd/out_regwrite
//                                         - registered instruction to EX
//           id_stall                      - decode must hold its instruction
//           mult_busy                     - MULTU in flight
// Revision: 1.0 - initial release
// ============================================================================
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FUNCT_W     = FUNCT_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [DATA_W-1:0]  in_dataA,
  input  logic [DATA_W-1:0]  in_dataB,
  input  logic [REG_W-1:0]   in_rd,
  input  logic               in_regwrite,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [FUNCT_W-1:0] out_funct,
  output logic [DATA_W-1:0]  out_dataA,
  output logic [DATA_W-1:0]  out_dataB,
  output logic [REG_W-1:0]   out_rd,
  output logic               out_regwrite,
  output logic               id_stall,
  output logic               mult_busy
);

  logic hazard;
  logic load_multu;

  // A MULTU only starts when it really enters EX: not flushed, not held
  // back by a downstream stall, and not itself blocked by the interlock.
  assign load_multu = in_valid & ~flush & ~ex_stall & ~hazard
                    & (in_funct == FUNCT_W'(FUNCT_MULTU));

  mult_interlock #(
    .FUNCT_W     (FUNCT_W),
    .MULT_CYCLES (MULT_CYCLES)
  ) u_mult_interlock (
    .clk        (clk),
    .rst        (rst),
    .load_multu (load_multu),
    .in_valid   (in_valid),
    .in_funct   (in_funct),
    .mult_busy  (mult_busy),
    .hazard     (hazard)
  );

  // A flushed instruction is discarded, so decode has no reason to hold it
  // for the interlock; only a downstream stall still forces a hold.
  assign id_stall = ex_stall | (hazard & ~flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_funct    <= '0;
      out_dataA    <= '0;
      out_dataB    <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
    end else if (flush || (!ex_stall && hazard)) begin
      out_valid    <= 1'b0;
      out_funct    <= FUNCT_W'(BUBBLE_FUNCT);
      out_dataA    <= '0;
      out_dataB    <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
    end else if (!ex_stall) begin
      out_valid    <= in_valid;
      out_funct    <= in_funct;
      out_dataA    <= in_dataA;
      out_dataB    <= in_dataB;
      out_rd       <= in_rd;
      out_regwrite <= in_regwrite & in_valid;
    end
  end

endmodule
`default_nettype wire
